// File: rtl/router_pkg.sv
// Shared router definitions: port count, mux select width, flit type,
// switch-allocator state encoding and a one-hot to index helper.
package router_pkg;

  localparam int NUM_PORTS   = 10;
  localparam int SEL_W       = 4;
  localparam int FLIT_W      = 32;
  localparam int ARB_CREDITS = 4;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

  // Converts a one-hot port vector to its index; returns 0 for an all-zero vector.
  function automatic logic [SEL_W-1:0] onehot2idx(input logic [NUM_PORTS-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: finds the first requester strictly after
// rr_ptr, wrapping modulo NUM_IN, so the last winner gets lowest priority.
module rr_arbiter #(
  parameter int NUM_IN = router_pkg::NUM_PORTS,
  parameter int SEL_W  = router_pkg::SEL_W
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  rr_ptr,
  output logic [SEL_W-1:0]  winner,
  output logic              any_req
);

  logic [SEL_W:0]   sum;
  logic [SEL_W-1:0] idx;
  logic             found;

  assign any_req = |req;

  // Walk the candidates in priority order starting just after rr_ptr; first hit wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      sum = {1'b0, rr_ptr} + (SEL_W+1)'(k);
      if (sum >= (SEL_W+1)'(NUM_IN)) sum = sum - (SEL_W+1)'(NUM_IN);
      idx = sum[SEL_W-1:0];
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Per-output-port switch allocator. Round-robin picks an input, locks it for a
// whole packet (head..tail) and forwards one flit per cycle under credit flow
// control, popping the owner's input buffer on every forwarded flit.
// Optional statistics counters (flit_cnt, stall_cnt) are built when the macro
// OUTPUT_ARB_STATS_EN is defined.
module output_port_arbiter #(
  parameter int NUM_IN  = router_pkg::NUM_PORTS,
  parameter int SEL_W   = router_pkg::SEL_W,
  parameter int CREDITS = router_pkg::ARB_CREDITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IN-1:0] req,
  input  logic [NUM_IN-1:0] tail,
  input  logic              credit_in,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_IN-1:0] grant,
  output logic              out_valid,
  output logic [NUM_IN-1:0] pop,
  output logic              credit_ovf
`ifdef OUTPUT_ARB_STATS_EN
  ,
  output logic [31:0]       flit_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  import router_pkg::*;

  localparam int               CNT_W   = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDITS);

  arb_state_e       state;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] owner;
  logic [SEL_W-1:0] winner;
  logic             any_req;
  logic [CNT_W-1:0] credit_cnt;
  logic             owner_req;
  logic             owner_tail;
  logic             has_credit;
  logic             send;

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_rr_arbiter (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  assign owner_req  = req[owner];
  assign owner_tail = tail[owner];
  assign has_credit = (credit_cnt != '0);
  assign send       = (state == ARB_LOCKED) && owner_req && has_credit;

  assign sel       = owner;
  assign out_valid = send;
  assign pop       = grant & {NUM_IN{send}};

  // Allocation FSM: lock a winner in IDLE, release it after its tail flit is sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ARB_IDLE;
      rr_ptr <= SEL_W'(NUM_IN - 1);
      owner  <= '0;
      grant  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            state <= ARB_LOCKED;
            owner <= winner;
            grant <= NUM_IN'(1) << winner;
          end
        end
        ARB_LOCKED: begin
          if (send && owner_tail) begin
            state  <= ARB_IDLE;
            rr_ptr <= owner;
            grant  <= '0;
          end
        end
      endcase
    end
  end

  // Downstream credit counter; a surplus credit saturates and raises a sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_cnt <= CNT_MAX;
      credit_ovf <= 1'b0;
    end else begin
      case ({send, credit_in})
        2'b10: credit_cnt <= credit_cnt - CNT_W'(1);
        2'b01: begin
          if (credit_cnt == CNT_MAX) credit_ovf <= 1'b1;
          else                       credit_cnt <= credit_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef OUTPUT_ARB_STATS_EN
  // Forwarded-flit counter (wraps) and credit-starvation counter (saturates).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (send) flit_cnt <= flit_cnt + 32'd1;
      if ((state == ARB_LOCKED) && owner_req && !has_credit && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: random packet traffic and credit returns are
// driven from modelled input buffers and a modelled downstream buffer; a
// packet-level reference model queues the expected per-cycle state and the
// expected flit transfers, and a monitor compares them against the design.
module tb_output_port_arbiter;

  localparam int NUM_IN  = 10;
  localparam int SEL_W   = 4;
  localparam int CREDITS = 4;

  logic              clk;
  logic              rst_n;
  logic [NUM_IN-1:0] req;
  logic [NUM_IN-1:0] tail;
  logic              credit_in;
  logic [SEL_W-1:0]  sel;
  logic [NUM_IN-1:0] grant;
  logic              out_valid;
  logic [NUM_IN-1:0] pop;
  logic              credit_ovf;
`ifdef OUTPUT_ARB_STATS_EN
  logic [31:0]       flit_cnt;
  logic [15:0]       stall_cnt;
`endif

  output_port_arbiter #(
    .NUM_IN  (NUM_IN),
    .SEL_W   (SEL_W),
    .CREDITS (CREDITS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .tail       (tail),
    .credit_in  (credit_in),
    .sel        (sel),
    .grant      (grant),
    .out_valid  (out_valid),
    .pop        (pop),
    .credit_ovf (credit_ovf)
`ifdef OUTPUT_ARB_STATS_EN
    ,
    .flit_cnt   (flit_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_IN-1:0] grant;
    logic [SEL_W-1:0]  sel;
    logic              out_valid;
    logic              credit_ovf;
  } exp_state_t;

  typedef struct packed {
    logic [31:0]      cyc;
    logic [SEL_W-1:0] port;
  } exp_xfer_t;

  exp_state_t state_q[$];
  exp_xfer_t  xfer_q[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] cycle    = 0;

  // Reference model: packet ownership, round-robin pointer, credits
  logic             m_locked;
  logic [SEL_W-1:0] m_owner;
  int               m_last;
  int               m_credits;
  logic             m_ovf;
  logic [31:0]      m_flits;
  int               m_stall;
  int               pending[NUM_IN];
  int               ds_count;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic modelReset();
    m_locked  = 1'b0;
    m_owner   = '0;
    m_last    = NUM_IN - 1;
    m_credits = CREDITS;
    m_ovf     = 1'b0;
    m_flits   = '0;
    m_stall   = 0;
    ds_count  = 0;
    for (int i = 0; i < NUM_IN; i++) pending[i] = 0;
  endtask

  task automatic applyStimulus(input int credit_pct);
    logic [NUM_IN-1:0] r;
    logic [NUM_IN-1:0] t;
    logic              ci;
    logic              send;
    logic [SEL_W-1:0]  so;
    logic [NUM_IN-1:0] eg;
    @(posedge clk);
    #1;
    cycle++;
    r = '0;
    t = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (pending[i] == 0 && $urandom_range(0, 99) < 15) pending[i] = int'($urandom_range(1, 5));
      r[SEL_W'(i)] = (pending[i] > 0) && ($urandom_range(0, 7) != 0);
      t[SEL_W'(i)] = r[SEL_W'(i)] ? (pending[i] == 1) : 1'($urandom_range(0, 1));
    end
    ci = (ds_count > 0) && (int'($urandom_range(0, 99)) < credit_pct);
    req       = r;
    tail      = t;
    credit_in = ci;

    so   = m_owner;
    send = m_locked && r[so] && (m_credits > 0);
    eg   = m_locked ? (NUM_IN'(1) << so) : '0;
    state_q.push_back('{grant: eg, sel: so, out_valid: send, credit_ovf: m_ovf});
    if (send) begin
      xfer_q.push_back('{cyc: cycle, port: so});
      m_flits = m_flits + 32'd1;
    end
    if (m_locked && r[so] && m_credits == 0 && m_stall < 65535) m_stall++;

    if (m_locked) begin
      if (send && t[so]) begin
        m_locked = 1'b0;
        m_last   = int'(so);
      end
    end else if (|r) begin
      for (int k = 1; k <= NUM_IN; k++) begin
        int c;
        c = (m_last + k) % NUM_IN;
        if (r[SEL_W'(c)]) begin
          m_owner  = SEL_W'(c);
          m_locked = 1'b1;
          break;
        end
      end
    end

    if (send && !ci) m_credits--;
    else if (!send && ci) begin
      if (m_credits == CREDITS) m_ovf = 1'b1;
      else m_credits++;
    end

    if (send) pending[int'(so)]--;
    ds_count = ds_count + int'(send) - int'(ci);
  endtask

  // Monitor: pops one expected state per cycle and one expected transfer per flit seen
  always @(negedge clk) begin
    if (state_q.size() > 0) begin
      exp_state_t es;
      es = state_q.pop_front();
      checkOutput("grant", 32'(grant), 32'(es.grant));
      checkOutput("sel", 32'(sel), 32'(es.sel));
      checkOutput("out_valid", 32'(out_valid), 32'(es.out_valid));
      checkOutput("credit_ovf", 32'(credit_ovf), 32'(es.credit_ovf));
      if (out_valid) begin
        if (xfer_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL xfer: unexpected flit from sel=%0d at cycle %0d", sel, cycle);
        end else begin
          exp_xfer_t ex;
          ex = xfer_q.pop_front();
          checkOutput("xfer_cycle", cycle, ex.cyc);
          checkOutput("xfer_sel", 32'(sel), 32'(ex.port));
          checkOutput("pop", 32'(pop), 32'(NUM_IN'(1) << ex.port));
        end
      end
    end
  end

  initial begin
    int extra;
    rst_n     = 1'b1;
    req       = '0;
    tail      = '0;
    credit_in = 1'b0;
    modelReset();
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_grant", 32'(grant), 32'h0);
    checkOutput("reset_sel", 32'(sel), 32'h0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset_pop", 32'(pop), 32'h0);
    checkOutput("reset_credit_ovf", 32'(credit_ovf), 32'h0);
    #19 rst_n = 1'b1;

    $display("[TB] random traffic: plentiful then scarce credits");
    for (int i = 0; i < 3000; i++) applyStimulus(i < 1500 ? 45 : 8);
    extra = 0;
    while (!m_locked && extra < 200) begin
      applyStimulus(45);
      extra++;
    end

    @(posedge clk);
    #2;
    checkOutput("xfer_queue_drained", 32'(xfer_q.size()), 32'h0);
    checkOutput("locked_grant", 32'(grant), m_locked ? 32'(NUM_IN'(1) << m_owner) : 32'h0);
`ifdef OUTPUT_ARB_STATS_EN
    checkOutput("flit_cnt", flit_cnt, m_flits);
    checkOutput("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif

    $display("[TB] asynchronous reset mid-packet");
    rst_n = 1'b0;
    #1;
    checkOutput("areset_grant", 32'(grant), 32'h0);
    checkOutput("areset_sel", 32'(sel), 32'h0);
    checkOutput("areset_out_valid", 32'(out_valid), 32'h0);
    checkOutput("areset_pop", 32'(pop), 32'h0);
    checkOutput("areset_credit_ovf", 32'(credit_ovf), 32'h0);
`ifdef OUTPUT_ARB_STATS_EN
    checkOutput("areset_flit_cnt", flit_cnt, 32'h0);
    checkOutput("areset_stall_cnt", 32'(stall_cnt), 32'h0);
`endif
    req       = '0;
    tail      = '0;
    credit_in = 1'b0;
    modelReset();
    @(negedge clk);
    #2 rst_n = 1'b1;

    $display("[TB] surplus credit raises sticky overflow");
    @(posedge clk);
    #1 credit_in = 1'b1;
    @(negedge clk);
    checkOutput("ovf_not_yet", 32'(credit_ovf), 32'h0);
    @(posedge clk);
    #1 credit_in = 1'b0;
    @(negedge clk);
    checkOutput("ovf_set", 32'(credit_ovf), 32'h1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("ovf_sticky", 32'(credit_ovf), 32'h1);
    checkOutput("idle_out_valid", 32'(out_valid), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("ovf_cleared", 32'(credit_ovf), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
